// File: rtl/pipe_chain.sv
// pipe_chain: stall- and flush-aware pipeline register chain with per-stage valid bits.
// Define PIPE_CHAIN_PERF_EN to build the stall/bubble/flush performance counters.
module pipe_chain #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall_req,
    input  logic [DEPTH-1:0]       flush_req,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       stall_cycles,
    output logic [CNT_W-1:0]       bubble_count,
    output logic [CNT_W-1:0]       flush_count
);
    logic [DEPTH-1:0]       valid_q, valid_d, prev_v;
    logic [DEPTH*WIDTH-1:0] data_q, data_d, prev_d;
    logic                   stall_eff, flush_eff;
    int                     s_idx, f_idx;

    for (genvar i = 0; i < DEPTH; i++) begin : g_prev
        if (i == 0) begin : g_in
            assign prev_v[i]              = in_valid;
            assign prev_d[i*WIDTH +: WIDTH] = in_data;
        end else begin : g_reg
            assign prev_v[i]              = valid_q[i-1];
            assign prev_d[i*WIDTH +: WIDTH] = data_q[(i-1)*WIDTH +: WIDTH];
        end
    end

    // An older flush kills the stalled instruction; otherwise the stall wins.
    always_comb begin
        s_idx = -1;
        f_idx = -1;
        for (int k = 0; k < DEPTH; k++) begin
            s_idx = stall_req[k] ? k : s_idx;
            f_idx = flush_req[k] ? k : f_idx;
        end
        flush_eff = (f_idx >= 0) && (f_idx > s_idx);
        stall_eff = (s_idx >= 0) && !flush_eff;
        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = (stall_eff && k <= s_idx) ? valid_q[k] :
                         (stall_eff && k == s_idx + 1) ? 1'b0 :
                         (flush_eff && k <= f_idx) ? 1'b0 : prev_v[k];
            data_d[k*WIDTH +: WIDTH] = (stall_eff && k <= s_idx + 1) ? data_q[k*WIDTH +: WIDTH]
                                                                   : prev_d[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready    = !stall_eff;
    assign stage_valid = valid_q;
    assign stage_data  = data_q;
    assign out_valid   = valid_q[DEPTH-1];
    assign out_data    = data_q[(DEPTH-1)*WIDTH +: WIDTH];

`ifdef PIPE_CHAIN_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q, flush_q;
    logic             bubble_inc;

    assign bubble_inc = stall_eff && (s_idx < DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            stall_q  <= (stall_eff && ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
            bubble_q <= (bubble_inc && ~&bubble_q) ? bubble_q + CNT_W'(1) : bubble_q;
            flush_q  <= (flush_eff && ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
        end
    end

    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
    assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed scenarios plus random stall/flush traffic checked against
// an entry-level reference model of the chain.
module tb_pipe_chain;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = 32;

    logic           clk, rst_n, in_valid, in_ready, out_valid;
    logic [W-1:0]   in_data, out_data;
    logic [D-1:0]   stall_req, flush_req, stage_valid;
    logic [D*W-1:0] stage_data;
    logic [CW-1:0]  stall_cycles, bubble_count, flush_count;

    int checks = 0;
    int errors = 0;

    bit             mv[D];
    logic [W-1:0]   md[D];
    longint         ms, mb, mf;

    pipe_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall_req(stall_req), .flush_req(flush_req),
        .stage_valid(stage_valid), .stage_data(stage_data), .out_valid(out_valid),
        .out_data(out_data), .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int top_bit(input logic [D-1:0] v);
        int r = -1;
        for (int k = 0; k < D; k++) if (v[k]) r = k;
        return r;
    endfunction

    function automatic bit stall_wins(input logic [D-1:0] st, input logic [D-1:0] fl);
        int s = top_bit(st);
        int f = top_bit(fl);
        return (s >= 0) && !(f >= 0 && f > s);
    endfunction

    function automatic longint perf(input longint v);
`ifdef PIPE_CHAIN_PERF_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < D; k++) begin
            mv[k] = 0;
            md[k] = '0;
        end
        ms = 0; mb = 0; mf = 0;
    endtask

    task automatic model_step(input logic v, input logic [W-1:0] d,
                              input logic [D-1:0] st, input logic [D-1:0] fl);
        int s = top_bit(st);
        int f = top_bit(fl);
        if (stall_wins(st, fl)) begin
            for (int k = D - 1; k >= s + 2; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            if (s + 1 < D) begin
                mv[s+1] = 0;
                mb++;
            end
            ms++;
        end else begin
            for (int k = D - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                md[k] = md[k-1];
            end
            mv[0] = v;
            md[0] = d;
            if (f >= 0) begin
                for (int k = 0; k <= f; k++) mv[k] = 0;
                mf++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < D; k++) begin
            chk($sformatf("%s valid[%0d]", tag, k), 64'(stage_valid[k]), 64'(mv[k]));
            chk($sformatf("%s data[%0d]", tag, k), 64'(stage_data[k*W +: W]), 64'(md[k]));
        end
        chk({tag, " out_valid"}, 64'(out_valid), 64'(mv[D-1]));
        chk({tag, " out_data"}, 64'(out_data), 64'(md[D-1]));
        chk({tag, " stall_cycles"}, 64'(stall_cycles), 64'(perf(ms)));
        chk({tag, " bubble_count"}, 64'(bubble_count), 64'(perf(mb)));
        chk({tag, " flush_count"}, 64'(flush_count), 64'(perf(mf)));
    endtask

    task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                         input logic [D-1:0] st, input logic [D-1:0] fl);
        in_valid  = v;
        in_data   = d;
        stall_req = st;
        flush_req = fl;
        #1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'(!stall_wins(st, fl)));
        @(posedge clk);
        model_step(v, d, st, fl);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; stall_req = '0; flush_req = '0;
        model_reset();
        #2;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        check_all("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_all("post_reset");

        // Free flow: A..D emerge back-to-back after DEPTH edges.
        cycle("flow", 1, 16'hA001, '0, '0);
        cycle("flow", 1, 16'hB002, '0, '0);
        cycle("flow", 1, 16'hC003, '0, '0);
        cycle("flow", 1, 16'hD004, '0, '0);
        chk("flow out A", 64'(out_data), 64'h A001);
        cycle("flow", 1, 16'hE005, '0, '0);
        chk("flow out B", 64'(out_data), 64'h B002);
        cycle("flow", 1, 16'hF006, '0, '0);
        chk("flow out C", 64'(out_data), 64'h C003);
        cycle("flow", 1, 16'h1007, '0, '0);
        chk("flow out D", 64'(out_data), 64'h D004);
        chk("flow out_valid", 64'(out_valid), 64'd1);

        // Memory stall at register 2 for three cycles.
        for (int n = 0; n < 3; n++) begin
            cycle("mem_stall", 1, 16'h2000 + 16'(n), 4'b0100, '0);
            chk("mem_stall bubble", 64'(stage_valid[3]), 64'd0);
        end
        cycle("mem_release", 1, 16'h2100, '0, '0);

        // Branch flush at register 2.
        cycle("branch", 1, 16'h3000, '0, 4'b0100);
        chk("branch kill", 64'(stage_valid[2:0]), 64'd0);
        cycle("branch_after", 1, 16'h3001, '0, '0);

        // Older flush beats younger stall, then older stall beats younger flush.
        cycle("flush_beats", 1, 16'h4000, 4'b0010, 4'b0100);
        cycle("refill", 1, 16'h4001, '0, '0);
        cycle("refill", 1, 16'h4002, '0, '0);
        cycle("refill", 1, 16'h4003, '0, '0);
        cycle("stall_beats", 1, 16'h5000, 4'b1000, 4'b0100);
        cycle("stall_beats", 1, 16'h5001, 4'b1000, 4'b0100);
        cycle("late_flush", 1, 16'h5002, '0, 4'b0100);

        // Random traffic with sparse stall/flush requests.
        for (int n = 0; n < 400; n++) begin
            logic [D-1:0] st, fl;
            st = ($urandom_range(0, 3) == 0) ? D'($urandom_range(1, 15)) : '0;
            fl = ($urandom_range(0, 5) == 0) ? D'($urandom_range(1, 15)) : '0;
            cycle("random", 1'($urandom), W'($urandom), st, fl);
        end

        // Reset asserted in the middle of a stall clears everything at once.
        cycle("pre_rst", 1, 16'h6000, '0, '0);
        cycle("pre_rst_stall", 1, 16'h6001, 4'b0010, '0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid_stall");
        @(posedge clk); #1;
        check_all("rst_held");
        rst_n = 1'b1;
        cycle("after_rst", 1, 16'h7000, '0, '0);
        cycle("after_rst", 1, 16'h7001, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
